// File: rtl/bira_pkg.sv
// Shared definitions for the BIRA fault collector: size defaults, CAM entry field
// offsets, the collector FSM state type and a saturating increment helper.
package bira_pkg;

    localparam int PCAM_DEF  = 8;
    localparam int NPCAM_DEF = 16;
    localparam int RS_DEF    = 2;
    localparam int CS_DEF    = 2;

    localparam int ADDR_W = 10;
    localparam int PTR_W  = 4;

    localparam int PIV_W     = 26;
    localparam int PIV_VLD   = 25;
    localparam int PIV_ROW   = 15;
    localparam int PIV_COL   = 5;
    localparam int PIV_RMUST = 4;
    localparam int PIV_CMUST = 3;

    localparam int NP_W    = 17;
    localparam int NP_VLD  = 16;
    localparam int NP_PTR  = 12;
    localparam int NP_DIR  = 11;
    localparam int NP_ADDR = 0;

    localparam int MUST_CNT_W = 5;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_DONE    = 2'd2,
        ST_FAIL    = 2'd3
    } state_t;

    function automatic logic [MUST_CNT_W-1:0] sat_inc(input logic [MUST_CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/fault_cam_collector_if.sv
// Fault stream handshake between the BIST engine (master) and the collector (slave).
interface fault_cam_collector_if;
    import bira_pkg::*;

    logic              fault_valid;
    logic [ADDR_W-1:0] fault_row;
    logic [ADDR_W-1:0] fault_col;
    logic              fault_ready;

    modport master (output fault_valid, fault_row, fault_col, input fault_ready);
    modport slave  (input fault_valid, fault_row, fault_col, output fault_ready);

endinterface

// File: rtl/cam_match_unit.sv
// Parallel compare of a fault address against every pivot entry, with a
// lowest-index priority encode for row and column matches.
module cam_match_unit
    import bira_pkg::*;
#(
    parameter int PCAM = PCAM_DEF
) (
    input  logic [PCAM-1:0]              piv_vld,
    input  logic [PCAM-1:0][ADDR_W-1:0]  piv_row,
    input  logic [PCAM-1:0][ADDR_W-1:0]  piv_col,
    input  logic [ADDR_W-1:0]            row,
    input  logic [ADDR_W-1:0]            col,
    output logic                         exact_hit,
    output logic                         row_hit,
    output logic                         col_hit,
    output logic [PTR_W-1:0]             row_idx,
    output logic [PTR_W-1:0]             col_idx
);

    // Scanning downward lets the lowest matching index be the last one written.
    always_comb begin
        exact_hit = 1'b0;
        row_hit   = 1'b0;
        col_hit   = 1'b0;
        row_idx   = '0;
        col_idx   = '0;
        for (int i = PCAM - 1; i >= 0; i--) begin
            if (piv_vld[i] && piv_row[i] == row) begin
                row_hit = 1'b1;
                row_idx = PTR_W'(i);
            end
            if (piv_vld[i] && piv_col[i] == col) begin
                col_hit = 1'b1;
                col_idx = PTR_W'(i);
            end
            if (piv_vld[i] && piv_row[i] == row && piv_col[i] == col) begin
                exact_hit = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fault_cam_collector.sv
// Collects BIST faults into pivot / nonpivot CAMs for spare allocation.
// Define FAULT_CAM_MUST_EN to add per-pivot row/col counters driving the must-repair bits.
module fault_cam_collector
    import bira_pkg::*;
#(
    parameter int PCAM  = PCAM_DEF,
    parameter int NPCAM = NPCAM_DEF,
    parameter int RS    = RS_DEF,
    parameter int CS    = CS_DEF
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    bist_start,
    input  logic                    bist_done,
    fault_cam_collector_if.slave    fault,
    output logic [PCAM*PIV_W-1:0]   pivot_fault_addr,
    output logic [NPCAM*NP_W-1:0]   nonpivot_fault_addr,
    output logic [4:0]              pcam_cnt,
    output logic [5:0]              npcam_cnt,
    output logic                    collect_done,
    output logic                    unrepairable
);

    localparam logic [4:0] PCAM_LIM  = 5'(PCAM);
    localparam logic [4:0] PIV_LIM   = 5'(RS + CS);
    localparam logic [5:0] NPCAM_LIM = 6'(NPCAM);

    state_t state, state_nxt;

    logic [PCAM-1:0]               piv_vld;
    logic [PCAM-1:0][ADDR_W-1:0]   piv_row;
    logic [PCAM-1:0][ADDR_W-1:0]   piv_col;
    logic [PCAM-1:0]               row_must;
    logic [PCAM-1:0]               col_must;
    logic [NPCAM-1:0]              np_vld;
    logic [NPCAM-1:0][PTR_W-1:0]   np_ptr;
    logic [NPCAM-1:0]              np_dir;
    logic [NPCAM-1:0][ADDR_W-1:0]  np_addr;

    logic              accept, exact_hit, row_hit, col_hit;
    logic [PTR_W-1:0]  row_idx, col_idx;
    logic              need_np, cand_dir, np_dup, drop, overflow;
    logic              store_piv, store_np;
    logic [PTR_W-1:0]  cand_ptr;
    logic [ADDR_W-1:0] cand_addr;

    assign accept = fault.fault_valid && fault.fault_ready;

    cam_match_unit #(.PCAM(PCAM)) u_match (
        .piv_vld   (piv_vld),
        .piv_row   (piv_row),
        .piv_col   (piv_col),
        .row       (fault.fault_row),
        .col       (fault.fault_col),
        .exact_hit (exact_hit),
        .row_hit   (row_hit),
        .col_hit   (col_hit),
        .row_idx   (row_idx),
        .col_idx   (col_idx)
    );

    // Row sharing wins over column sharing when a fault touches two pivots.
    always_comb begin
        need_np   = row_hit || col_hit;
        cand_dir  = row_hit;
        cand_ptr  = row_hit ? row_idx : col_idx;
        cand_addr = row_hit ? fault.fault_col : fault.fault_row;
        np_dup    = 1'b0;
        for (int j = 0; j < NPCAM; j++) begin
            if (np_vld[j] && np_ptr[j] == cand_ptr && np_dir[j] == cand_dir &&
                np_addr[j] == cand_addr) begin
                np_dup = 1'b1;
            end
        end
        drop      = exact_hit || (need_np && np_dup);
        overflow  = !drop && (need_np ? (npcam_cnt == NPCAM_LIM)
                                      : (pcam_cnt == PCAM_LIM || pcam_cnt >= PIV_LIM));
        store_np  = accept && !drop && !overflow && need_np;
        store_piv = accept && !drop && !overflow && !need_np;
    end

    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (bist_start) begin
            state_nxt = ST_COLLECT;
        end else begin
            case (state)
                ST_COLLECT: begin
                    if (accept && overflow) state_nxt = ST_FAIL;
                    else if (bist_done)     state_nxt = ST_DONE;
                end
                default: state_nxt = state;
            endcase
        end
    end

    always_comb begin
        fault.fault_ready = (state == ST_COLLECT);
        collect_done      = (state == ST_DONE);
        unrepairable      = (state == ST_FAIL);
    end

    // bist_start wipes the CAM on the same edge that enters COLLECT.
    always_ff @(posedge clk) begin
        if (rst || bist_start) begin
            piv_vld   <= '0;
            piv_row   <= '0;
            piv_col   <= '0;
            np_vld    <= '0;
            np_ptr    <= '0;
            np_dir    <= '0;
            np_addr   <= '0;
            pcam_cnt  <= '0;
            npcam_cnt <= '0;
        end else begin
            if (store_piv) begin
                for (int i = 0; i < PCAM; i++) begin
                    if (5'(i) == pcam_cnt) begin
                        piv_vld[i] <= 1'b1;
                        piv_row[i] <= fault.fault_row;
                        piv_col[i] <= fault.fault_col;
                    end
                end
                pcam_cnt <= pcam_cnt + 5'd1;
            end
            if (store_np) begin
                for (int j = 0; j < NPCAM; j++) begin
                    if (6'(j) == npcam_cnt) begin
                        np_vld[j]  <= 1'b1;
                        np_ptr[j]  <= cand_ptr;
                        np_dir[j]  <= cand_dir;
                        np_addr[j] <= cand_addr;
                    end
                end
                npcam_cnt <= npcam_cnt + 6'd1;
            end
        end
    end

`ifdef FAULT_CAM_MUST_EN
    localparam logic [MUST_CNT_W-1:0] ROW_LIM = MUST_CNT_W'(CS);
    localparam logic [MUST_CNT_W-1:0] COL_LIM = MUST_CNT_W'(RS);

    logic [PCAM-1:0][MUST_CNT_W-1:0] row_cnt;
    logic [PCAM-1:0][MUST_CNT_W-1:0] col_cnt;

    // Each count includes the pivot itself, so a fresh pivot starts at one.
    always_ff @(posedge clk) begin
        if (rst || bist_start) begin
            row_cnt <= '0;
            col_cnt <= '0;
        end else begin
            for (int i = 0; i < PCAM; i++) begin
                if (store_piv && 5'(i) == pcam_cnt) begin
                    row_cnt[i] <= MUST_CNT_W'(1);
                    col_cnt[i] <= MUST_CNT_W'(1);
                end
                if (store_np && PTR_W'(i) == cand_ptr) begin
                    if (cand_dir) row_cnt[i] <= sat_inc(row_cnt[i]);
                    else          col_cnt[i] <= sat_inc(col_cnt[i]);
                end
            end
        end
    end

    always_comb begin
        for (int i = 0; i < PCAM; i++) begin
            row_must[i] = (row_cnt[i] > ROW_LIM);
            col_must[i] = (col_cnt[i] > COL_LIM);
        end
    end
`else
    assign row_must = '0;
    assign col_must = '0;
`endif

    always_comb begin
        pivot_fault_addr    = '0;
        nonpivot_fault_addr = '0;
        for (int i = 0; i < PCAM; i++) begin
            pivot_fault_addr[PIV_W*i + PIV_VLD]             = piv_vld[i];
            pivot_fault_addr[PIV_W*i + PIV_ROW +: ADDR_W]   = piv_row[i];
            pivot_fault_addr[PIV_W*i + PIV_COL +: ADDR_W]   = piv_col[i];
            pivot_fault_addr[PIV_W*i + PIV_RMUST]           = row_must[i];
            pivot_fault_addr[PIV_W*i + PIV_CMUST]           = col_must[i];
        end
        for (int j = 0; j < NPCAM; j++) begin
            nonpivot_fault_addr[NP_W*j + NP_VLD]            = np_vld[j];
            nonpivot_fault_addr[NP_W*j + NP_PTR +: PTR_W]   = np_ptr[j];
            nonpivot_fault_addr[NP_W*j + NP_DIR]            = np_dir[j];
            nonpivot_fault_addr[NP_W*j + NP_ADDR +: ADDR_W] = np_addr[j];
        end
    end

endmodule

// File: tb/tb_fault_cam_collector.sv
// Scoreboard bench for fault_cam_collector: a list-based reference model predicts the
// CAM image after every accepted fault; a negedge monitor compares it one cycle later.
module tb_fault_cam_collector;
    import bira_pkg::*;

    localparam int P  = 8;
    localparam int NP = 16;
    localparam int R  = 2;
    localparam int C  = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic bist_start = 1'b0;
    logic bist_done = 1'b0;
    always #5 clk = ~clk;

    fault_cam_collector_if fif();

    logic [P*26-1:0]  pv;
    logic [NP*17-1:0] npv;
    logic [4:0]       pc;
    logic [5:0]       nc;
    logic             cd, unr;

    fault_cam_collector #(.PCAM(P), .NPCAM(NP), .RS(R), .CS(C)) dut (
        .clk                 (clk),
        .rst                 (rst),
        .bist_start          (bist_start),
        .bist_done           (bist_done),
        .fault               (fif),
        .pivot_fault_addr    (pv),
        .nonpivot_fault_addr (npv),
        .pcam_cnt            (pc),
        .npcam_cnt           (nc),
        .collect_done        (cd),
        .unrepairable        (unr)
    );

    typedef struct {
        logic [P*26-1:0]  piv;
        logic [NP*17-1:0] np;
        logic [4:0]       pc;
        logic [5:0]       nc;
        logic             rdy, done, unr;
    } snap_t;

    int checks = 0;
    int failures = 0;
    snap_t sb[$];

    // Reference model: 0 idle, 1 collecting, 2 done, 3 fail; CAM as plain lists.
    int mstate = 0;
    int prow[$], pcol[$], nptr[$], ndir[$], naddr[$];

    function automatic void model_clear();
        prow.delete(); pcol.delete(); nptr.delete(); ndir.delete(); naddr.delete();
    endfunction

    function automatic snap_t model_snap();
        snap_t s;
        s.piv = '0;
        s.np  = '0;
        foreach (prow[i]) begin
            s.piv[26*i +: 26] = {1'b1, 10'(prow[i]), 10'(pcol[i]), 5'b00000};
`ifdef FAULT_CAM_MUST_EN
            begin
                int rc, cc;
                rc = 1; cc = 1;
                foreach (nptr[k]) if (nptr[k] == i) begin
                    if (ndir[k] == 1) rc++; else cc++;
                end
                s.piv[26*i + 4] = (rc > C);
                s.piv[26*i + 3] = (cc > R);
            end
`endif
        end
        foreach (nptr[k]) s.np[17*k +: 17] = {1'b1, 4'(nptr[k]), 1'(ndir[k]), 1'b0, 10'(naddr[k])};
        s.pc   = 5'(prow.size());
        s.nc   = 6'(nptr.size());
        s.rdy  = (mstate == 1);
        s.done = (mstate == 2);
        s.unr  = (mstate == 3);
        return s;
    endfunction

    function automatic void model_fault(int r, int c);
        int ptr, dir, addr;
        foreach (prow[i]) if (prow[i] == r && pcol[i] == c) return;
        ptr = -1; dir = 0; addr = 0;
        foreach (prow[i]) if (ptr < 0 && prow[i] == r) begin ptr = i; dir = 1; addr = c; end
        if (ptr < 0) foreach (pcol[i]) if (ptr < 0 && pcol[i] == c) begin ptr = i; dir = 0; addr = r; end
        if (ptr >= 0) begin
            foreach (nptr[k]) if (nptr[k] == ptr && ndir[k] == dir && naddr[k] == addr) return;
            if (nptr.size() == NP) begin mstate = 3; return; end
            nptr.push_back(ptr); ndir.push_back(dir); naddr.push_back(addr);
        end else begin
            if (prow.size() == P || prow.size() + 1 > R + C) begin mstate = 3; return; end
            prow.push_back(r); pcol.push_back(c);
        end
    endfunction

    task automatic cmp(input string nm, input logic [511:0] act, input logic [511:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic compare_snap(input snap_t e, input string tag);
        cmp({tag, ".pivots"}, 512'(pv), 512'(e.piv));
        cmp({tag, ".nonpivots"}, 512'(npv), 512'(e.np));
        cmp({tag, ".pcam_cnt"}, 512'(pc), 512'(e.pc));
        cmp({tag, ".npcam_cnt"}, 512'(nc), 512'(e.nc));
        cmp({tag, ".fault_ready"}, 512'(fif.fault_ready), 512'(e.rdy));
        cmp({tag, ".collect_done"}, 512'(cd), 512'(e.done));
        cmp({tag, ".unrepairable"}, 512'(unr), 512'(e.unr));
    endtask

    // Drive one cycle of stimulus and advance the model across the coming edge.
    task automatic tick(input logic v, input int r, input int c,
                        input logic st, input logic dn, input logic rs);
        logic acc;
        @(posedge clk);
        #1;
        fif.fault_valid = v;
        fif.fault_row   = 10'(r);
        fif.fault_col   = 10'(c);
        bist_start      = st;
        bist_done       = dn;
        rst             = rs;
        acc = v && (mstate == 1);
        if (rs) begin
            model_clear(); mstate = 0;
        end else if (st) begin
            model_clear(); mstate = 1;
        end else if (mstate == 1) begin
            if (v) model_fault(r, c);
            if (mstate == 1 && dn) mstate = 2;
        end
        if (acc) sb.push_back(model_snap());
    endtask

    task automatic check_now(input string tag);
        tick(1'b0, 0, 0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        compare_snap(model_snap(), tag);
    endtask

    task automatic send(input int r, input int c);
        tick(1'b1, r, c, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic start();
        tick(1'b0, 0, 0, 1'b1, 1'b0, 1'b0);
    endtask

    // Monitor: an accept seen on one negedge is checked against the queue on the next.
    initial begin
        logic pend;
        pend = 1'b0;
        forever begin
            @(negedge clk);
            if (pend) begin
                if (sb.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL sb_underflow: got accepted fault, expected none");
                end else begin
                    compare_snap(sb.pop_front(), "accept");
                end
            end
            pend = (fif.fault_valid === 1'b1) && (fif.fault_ready === 1'b1);
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        logic v, dn, rs;
        fif.fault_valid = 1'b0;
        fif.fault_row   = '0;
        fif.fault_col   = '0;

        tick(1'b0, 0, 0, 1'b0, 1'b0, 1'b1);
        tick(1'b0, 0, 0, 1'b0, 1'b0, 1'b1);
        check_now("reset");

        // Pivot with one row-sharing and one column-sharing nonpivot
        start();
        send(5, 7); send(5, 9); send(3, 7);
        check_now("basic");
        cmp("basic.piv0", 512'(pv[25:0]), 512'({1'b1, 10'd5, 10'd7, 5'd0}));
        cmp("basic.np0", 512'(npv[16:0]), 512'({1'b1, 4'd0, 1'b1, 1'b0, 10'd9}));
        cmp("basic.np1", 512'(npv[33:17]), 512'({1'b1, 4'd0, 1'b0, 1'b0, 10'd3}));

        // Duplicate fault
        start();
        send(5, 7); send(5, 7);
        check_now("dup");
        cmp("dup.pcam_cnt", 512'(pc), 512'(1));
        cmp("dup.npcam_cnt", 512'(nc), 512'(0));

        // Pivot overflow beyond RS+CS
        start();
        for (int i = 1; i <= 5; i++) send(i, i);
        check_now("piv_ovf");
        cmp("piv_ovf.unrepairable", 512'(unr), 512'(1));
        cmp("piv_ovf.pcam_cnt", 512'(pc), 512'(4));
        cmp("piv_ovf.fault_ready", 512'(fif.fault_ready), 512'(0));

`ifdef FAULT_CAM_MUST_EN
        start();
        send(1, 1); send(1, 2); send(1, 3);
        check_now("must");
        cmp("must.row_must", 512'(pv[4]), 512'(1));
`endif

        // Nonpivot CAM overflow
        start();
        send(0, 0);
        for (int i = 1; i <= 17; i++) send(0, i);
        check_now("np_ovf");
        cmp("np_ovf.npcam_cnt", 512'(nc), 512'(16));

        // Fault accepted alongside bist_done, then reset
        start();
        tick(1'b1, 6, 6, 1'b0, 1'b1, 1'b0);
        check_now("done_same");
        cmp("done_same.collect_done", 512'(cd), 512'(1));
        cmp("done_same.pcam_cnt", 512'(pc), 512'(1));
        tick(1'b0, 0, 0, 1'b0, 1'b1, 1'b0);
        check_now("done_ignored");
        tick(1'b0, 0, 0, 1'b0, 1'b0, 1'b1);
        check_now("rst_after_done");
        cmp("rst_after_done.pivots", 512'(pv), 512'(0));
        tick(1'b0, 0, 0, 1'b0, 1'b1, 1'b0);
        check_now("idle_done_ignored");
        tick(1'b0, 0, 0, 1'b1, 1'b1, 1'b0);
        check_now("start_over_done");

        // Randomized episodes
        for (int ep = 0; ep < 40; ep++) begin
            start();
            n = $urandom_range(5, 30);
            for (int k = 0; k < n; k++) begin
                v  = ($urandom_range(0, 9) < 7);
                dn = ($urandom_range(0, 19) == 0);
                rs = ($urandom_range(0, 59) == 0);
                tick(v, $urandom_range(0, 5), $urandom_range(0, 5), 1'b0, dn, rs);
            end
            check_now("random");
        end

        check_now("final");
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL sb_drain: got %0d pending, expected 0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
